tqvp_sprite_engine_n: RTL and testbench
=======================================

Name: tqvp_sprite_engine_n

Overview:
Parametrised multi-sprite XGA overlay peripheral on the TinyQV peripheral bus. It drives 2-bit-per-channel RGB plus HSYNC and VSYNC on uo_out. The block provides NUM_SPR bitmap sprites with per-sprite enable, palette and horizontal flip, loaded through an auto-incrementing bitmap port. Positions are double-buffered and latched at the start of VSYNC. Sprite-to-sprite pixel collisions are flagged in a sticky register and can raise an interrupt.

Parameters:
NUM_SPR, 4, number of sprites (1..8).
SPR_W, 12, sprite width in logical pixels (1..16).
SPR_H, 12, sprite height in rows (1..16).
SCALE_SHIFT, 2, logical pixel size is 2^SCALE_SHIFT screen pixels per axis.
H_ACTIVE/H_FP/H_SYNC/H_TOTAL, 1024/24/136/1344, horizontal timing in clocks.
V_ACTIVE/V_FP/V_SYNC/V_TOTAL, 768/3/6/806, vertical timing in lines.

Ports:
clk  in  1  peripheral clock (64 MHz nominal)
rst_n  in  1  asynchronous active-low reset
ui_in  in  8  unused
uo_out  out  8  {vsync, hsync, R[1:0], G[1:0], B[1:0]}
address  in  6  byte address within peripheral
data_in  in  32  write data
data_write_n  in  2  11 = none; 00/01/10 = 8/16/32-bit write
data_read_n  in  2  11 = none; other values = read
data_out  out  32  combinational read data
data_ready  out  1  constant 1
user_interrupt  out  1  OR of enabled pending flags

Behaviour:
- Reset (async, rst_n low): every register, bitmap, counter and flag is cleared, so uo_out = 0 and user_interrupt = 0 immediately. Release is synchronous to clk.
- Any write width is accepted, with data taken from data_in LSBs. Addresses match exactly. Unmapped reads return 0.
- Register map:
  - 0x00 CTRL: [0] stream enable, [1] VSYNC IRQ enable, [2] collision IRQ enable.
  - 0x04 STATUS: [0] vsync_pend, [1] coll_pend. Write-1-to-clear.
  - 0x08 BMP_PTR: [2:0] sprite index, [11:8] row. A written row >= SPR_H is stored as 0.
  - 0x0C BMP_DATA:
    - Write stores data_in[SPR_W-1:0] into the selected sprite row, then row increments; row SPR_H-1 wraps to 0 with the same sprite.
    - Write is ignored, with no pointer increment, if sprite index >= NUM_SPR.
    - Read returns the row without incrementing.
  - 0x10+4*i SPR_i shadow (i < NUM_SPR): [7:0] x, [15:8] y, [17:16] palette, [18] hflip, [19] enable.
  - 0x30 COLL: [NUM_SPR-1:0] sticky per-sprite collision bits. Write-1-to-clear.
- Timing when CTRL[0] = 1:
  - h_cnt wraps at H_TOTAL-1; v_cnt increments on that wrap and itself wraps at V_TOTAL-1.
  - hsync is high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v_cnt. Both syncs are positive polarity.
- When CTRL[0] = 0: counters are forced to 0 and uo_out = 0. Pending flags and COLL are retained.
- Pipeline: uo_out is registered. Syncs and RGB for counter value (h, v) appear together one clk later.
- Sprite hit, using lx = h_cnt >> SCALE_SHIFT and ly = v_cnt >> SCALE_SHIFT truncated to 8 bits:
  - Comparison is 9-bit: x <= lx < x+SPR_W and y <= ly < y+SPR_H. There is no wrap to the opposite screen edge.
  - col = lx-x, or SPR_W-1-(lx-x) when hflip = 1. row = ly-y.
  - The sprite is opaque when enabled, the pixel is in the active area, and bitmap[row][col] = 1.
- Composition: the highest-index opaque sprite wins. Palette: 0 = 00_00_11, 1 = 00_11_00, 2 = 11_00_00, 3 = 11_11_11. Background is 000000.
- Collision: on any active pixel where two or more sprites are opaque, every opaque sprite's COLL bit is set.
- Active positions: shadow SPR_i registers are copied to active registers on the clk after the vsync rising edge (0 to 1). Mid-frame shadow writes do not affect the frame. Bitmap writes take effect immediately.
- Pending flags:
  - vsync_pend sets on the vsync rising edge if CTRL[1] = 1.
  - coll_pend sets on the cycle COLL changes from all-zero to non-zero, if CTRL[2] = 1.
  - Set beats a write-1-to-clear in the same cycle, for both STATUS and COLL.
- user_interrupt = (vsync_pend & CTRL[1]) | (coll_pend & CTRL[2]).

Test Plan:
- Reset: assert rst_n low mid-frame with sprites visible -> uo_out = 0x00 asynchronously; all registers read 0 after release.
- Bitmap port: write BMP_PTR = 0x0001 (sprite 1, row 0), then 13 BMP_DATA writes of values n = 0..12 -> row 0 holds 12 (wrapped), rows 1..11 hold 1..11; BMP_DATA readback at PTR row 3 = 3.
- Render:
  - Setup: sprite 0 row 0 = 0x001, enable = 1, x = 10, y = 5, palette = 2.
  - Unflipped: h_cnt = 40..43, v_cnt = 20 -> uo_out[5:0] = 110000 one clk later; h_cnt = 44 -> 000000.
  - hflip = 1: pixel appears at lx = 21.
- Priority and collision:
  - Setup: sprites 0 and 2 with full bitmaps at the same x/y, palettes 0 and 3, CTRL = 0x05.
  - Expected: overlap pixel shows 111111; COLL = 0b0101; coll_pend = 1; user_interrupt = 1.
  - Clear: write 0x2 to STATUS in the same cycle as a new collision -> coll_pend stays 1.
- Double-buffer: write SPR_0 x = 50 mid-frame -> current frame still renders at old x; new x is used from the next frame; vsync_pend sets at v_cnt = 771 with CTRL[1] = 1.
- Edge clip: x = 250, SPR_W = 12 -> pixels drawn for lx 250..255 only; no pixel at lx 0..5.

Source files
------------

// File: rtl/tqvp_sprite_engine_n.sv
// rtl/tqvp_sprite_engine_n.sv - multi-sprite XGA overlay peripheral for the TinyQV bus
module tqvp_sprite_engine_n #(
  parameter int NUM_SPR     = 4,
  parameter int SPR_W       = 12,
  parameter int SPR_H       = 12,
  parameter int SCALE_SHIFT = 2,
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_TOTAL     = 1344,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_TOTAL     = 806
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int SIW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  // Bus-visible state
  logic [2:0]         ctrl;
  logic               vsync_pend;
  logic               coll_pend;
  logic [2:0]         bmp_spr;
  logic [RW-1:0]      bmp_row;
  logic [SPR_W-1:0]   bmp [NUM_SPR][SPR_H];
  logic [19:0]        sh  [NUM_SPR];
  logic [19:0]        act [NUM_SPR];
  logic [NUM_SPR-1:0] coll;

  // Video timing state
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          vsync_d;

  logic                wr;
  logic                spr_valid;
  logic [SIW-1:0]      spr_idx;
  logic                hsync_c, vsync_c, vsync_rise, in_act;
  logic [7:0]          lx, ly;
  logic [NUM_SPR-1:0]  opaque;
  logic [NUM_SPR-1:0]  coll_set, coll_clr;
  logic                coll_event;
  logic [1:0]          st_clr;
  logic                any_opaque;
  logic [1:0]          win_pal;
  logic [5:0]          rgb;
  logic [31:0]         rdata;
  logic                unused;

  assign unused     = &{1'b0, ui_in, data_read_n, data_in};
  assign data_ready = 1'b1;
  assign wr         = (data_write_n != 2'b11);
  assign spr_valid  = ({1'b0, bmp_spr} < 4'(NUM_SPR));
  assign spr_idx    = bmp_spr[SIW-1:0];

  assign hsync_c    = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_c    = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign vsync_rise = vsync_c & ~vsync_d;
  assign in_act     = ctrl[0] && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign lx         = 8'(h_cnt >> SCALE_SHIFT);
  assign ly         = 8'(v_cnt >> SCALE_SHIFT);

  // Per-sprite hit test; 9-bit bounds keep sprites near the right edge from wrapping to x=0
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    logic [7:0]    sx, sy;
    logic [CW-1:0] col_raw, col;
    logic [RW-1:0] row;
    logic          in_x, in_y;
    assign sx      = act[i][7:0];
    assign sy      = act[i][15:8];
    assign in_x    = (lx >= sx) && ({1'b0, lx} < ({1'b0, sx} + 9'(SPR_W)));
    assign in_y    = (ly >= sy) && ({1'b0, ly} < ({1'b0, sy} + 9'(SPR_H)));
    assign col_raw = CW'(lx - sx);
    assign col     = act[i][18] ? (CW'(SPR_W - 1) - col_raw) : col_raw;
    assign row     = RW'(ly - sy);
    assign opaque[i] = in_act && act[i][19] && in_x && in_y && bmp[i][row][col];
  end

  // Two or more opaque sprites flag every opaque one
  assign coll_set   = ((opaque & (opaque - 1'b1)) != '0) ? opaque : '0;
  assign coll_clr   = (wr && address == 6'h30) ? data_in[NUM_SPR-1:0] : '0;
  assign st_clr     = (wr && address == 6'h04) ? data_in[1:0] : 2'b00;
  assign coll_event = ctrl[2] && (coll == '0) && (coll_set != '0);

  // Highest-index opaque sprite selects the palette
  always_comb begin
    any_opaque = 1'b0;
    win_pal    = 2'b00;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (opaque[i]) begin
        any_opaque = 1'b1;
        win_pal    = act[i][17:16];
      end
    end
  end

  // Palette lookup into {R, G, B}
  always_comb begin
    rgb = 6'b000000;
    if (any_opaque) begin
      case (win_pal)
        2'd0:    rgb = 6'b000011;
        2'd1:    rgb = 6'b001100;
        2'd2:    rgb = 6'b110000;
        default: rgb = 6'b111111;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (address)
      6'h00:   rdata = {29'd0, ctrl};
      6'h04:   rdata = {30'd0, coll_pend, vsync_pend};
      6'h08:   rdata = {20'd0, 4'(bmp_row), 5'd0, bmp_spr};
      6'h0C:   if (spr_valid) rdata = 32'(bmp[spr_idx][bmp_row]);
      6'h30:   rdata = 32'(coll);
      default: rdata = '0;
    endcase
    for (int i = 0; i < NUM_SPR; i++) begin
      if (address == 6'(16 + 4 * i)) rdata = 32'(sh[i]);
    end
  end
  assign data_out = rdata;

  assign user_interrupt = (vsync_pend & ctrl[1]) | (coll_pend & ctrl[2]);

  // Bitmap pointer and storage; invalid sprite index leaves pointer and bitmap untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmp_spr <= '0;
      bmp_row <= '0;
      for (int i = 0; i < NUM_SPR; i++)
        for (int r = 0; r < SPR_H; r++)
          bmp[i][r] <= '0;
    end else if (wr && address == 6'h08) begin
      bmp_spr <= data_in[2:0];
      bmp_row <= ({1'b0, data_in[11:8]} < 5'(SPR_H)) ? RW'(data_in[11:8]) : '0;
    end else if (wr && address == 6'h0C && spr_valid) begin
      bmp[spr_idx][bmp_row] <= data_in[SPR_W-1:0];
      bmp_row <= (bmp_row == RW'(SPR_H - 1)) ? '0 : bmp_row + 1'b1;
    end
  end

  // Control, shadow/active positions, sticky flags; a set always beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl       <= '0;
      vsync_pend <= 1'b0;
      coll_pend  <= 1'b0;
      coll       <= '0;
      vsync_d    <= 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
        sh[i]  <= '0;
        act[i] <= '0;
      end
    end else begin
      if (wr && address == 6'h00) ctrl <= data_in[2:0];
      for (int i = 0; i < NUM_SPR; i++) begin
        if (wr && address == 6'(16 + 4 * i)) sh[i] <= data_in[19:0];
        if (vsync_rise) act[i] <= sh[i];
      end
      vsync_d    <= vsync_c;
      coll       <= (coll & ~coll_clr) | coll_set;
      vsync_pend <= (vsync_pend & ~st_clr[0]) | (vsync_rise & ctrl[1]);
      coll_pend  <= (coll_pend & ~st_clr[1]) | coll_event;
    end
  end

  // Raster counters, held at zero while the stream is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!ctrl[0]) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered video output: syncs and colour for one counter value leave together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= 8'h00;
    else        uo_out <= ctrl[0] ? {vsync_c, hsync_c, rgb} : 8'h00;
  end

endmodule

// File: tb/tb_tqvp_sprite_engine_n.sv
// tb/tb_tqvp_sprite_engine_n.sv - self-checking bench for tqvp_sprite_engine_n
module tb_tqvp_sprite_engine_n;

  localparam int H_ACTIVE = 512, H_FP = 8, H_SYNC = 32, H_TOTAL = 560;
  localparam int V_ACTIVE = 12,  V_FP = 1, V_SYNC = 2,  V_TOTAL = 16;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [7:0]  uo_out;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_sprite_engine_n #(
    .NUM_SPR(4), .SPR_W(12), .SPR_H(12), .SCALE_SHIFT(1),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails = 0;
  int total = 0;

  // Bench-side raster position, derived from the CTRL writes the bench issues
  logic en_m;
  int   h_m, v_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_m <= 1'b0; h_m <= 0; v_m <= 0;
    end else begin
      if (!en_m) begin
        h_m <= 0; v_m <= 0;
      end else if (h_m == H_TOTAL - 1) begin
        h_m <= 0;
        v_m <= (v_m == V_TOTAL - 1) ? 0 : v_m + 1;
      end else begin
        h_m <= h_m + 1;
      end
      if (data_write_n != 2'b11 && address == 6'h00) en_m <= data_in[0];
    end
  end

  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
    @(posedge clk);
    #1 data_write_n = 2'b11;
    @(negedge clk);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    address = a; data_read_n = 2'b00;
    #1 check(tag, data_out, exp);
    data_read_n = 2'b11;
    @(negedge clk);
  endtask

  task automatic wait_at(input int h, input int v, input string tag);
    int n = 0;
    while (!(h_m == h && v_m == v) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, 32'(h_m == h && v_m == v), 32'd1);
  endtask

  function automatic logic [7:0] exp_uo(input int h, input int v, input logic [5:0] rgb);
    logic vs, hs;
    vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    return {vs, hs, rgb};
  endfunction

  // Push expectation when the raster reaches (h,v); compare once the registered pixel emerges
  task automatic pix(input int h, input int v, input logic [5:0] rgb, input string tag);
    logic [7:0] e;
    string t;
    wait_at(h, v, tag);
    exp_q.push_back(exp_uo(h, v, rgb));
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(uo_out), 32'(e));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo", 32'(uo_out), 32'h0);
    check("rst_irq", 32'(user_interrupt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("data_ready", 32'(data_ready), 32'h1);
    rd(6'h00, 32'h0, "rst_ctrl");
    rd(6'h04, 32'h0, "rst_status");
    rd(6'h08, 32'h0, "rst_ptr");
    rd(6'h10, 32'h0, "rst_spr0");
    rd(6'h30, 32'h0, "rst_coll");
    rd(6'h3C, 32'h0, "unmapped");

    // Bitmap port: 13 writes to sprite 1 wrap row 11 -> 0
    wr(6'h08, 32'h0001);
    for (int n = 0; n < 13; n++) wr(6'h0C, 32'(n));
    rd(6'h08, 32'h0101, "ptr_after_wrap");
    wr(6'h08, 32'h0001);
    rd(6'h0C, 32'd12, "bmp_row0");
    wr(6'h08, 32'h0301);
    rd(6'h0C, 32'd3, "bmp_row3");
    rd(6'h0C, 32'd3, "bmp_row3_again");
    rd(6'h08, 32'h0301, "ptr_no_read_inc");
    wr(6'h08, 32'h0B01);
    rd(6'h0C, 32'd11, "bmp_row11");
    wr(6'h08, 32'h0C01);
    rd(6'h08, 32'h0001, "ptr_row_clamp");
    wr(6'h08, 32'h0005);
    wr(6'h0C, 32'h0ABC);
    rd(6'h08, 32'h0005, "ptr_bad_spr_no_inc");

    // Render setup: sprite 0 single pixel, sprite 3 at the right edge
    wr(6'h08, 32'h0000);
    wr(6'h0C, 32'h001);
    wr(6'h08, 32'h0003);
    wr(6'h0C, 32'hFFF);
    wr(6'h10, 32'h000A_050A);
    wr(6'h1C, 32'h0009_00FA);
    rd(6'h10, 32'h000A_050A, "spr0_shadow");
    wr(6'h00, 32'h1);

    // Frame 2: first frame using latched positions
    wait_at(0, V_TOTAL - 2, "f1_end");
    pix(0,   0, 6'h00, "clip_lx0");
    pix(10,  0, 6'h00, "clip_lx5");
    pix(500, 0, 6'h0C, "clip_lx250");
    pix(511, 0, 6'h0C, "clip_lx255");
    pix(512, 0, 6'h00, "clip_h512");
    pix(19, 10, 6'h00, "r_lx9");
    pix(20, 10, 6'h30, "r_lx10a");
    pix(21, 10, 6'h30, "r_lx10b");
    pix(22, 10, 6'h00, "r_lx11");
    pix(519, 10, 6'h00, "hs_before");
    pix(520, 10, 6'h00, "hs_first");
    pix(0, 13, 6'h00, "vs_first");
    pix(0, 15, 6'h00, "vs_after");

    // Frame 3: mid-frame shadow write (x=30, hflip) must not affect this frame
    wait_at(0, 5, "f3_mid");
    wr(6'h10, 32'h000E_051E);
    wr(6'h00, 32'h3);
    pix(20, 10, 6'h30, "db_old_x");
    pix(82, 10, 6'h00, "db_new_not_yet");
    wait_at(0, 13, "vs_edge");
    rd(6'h04, 32'h0, "vpend_before");
    rd(6'h04, 32'h1, "vpend_set");
    check("irq_vsync", 32'(user_interrupt), 32'h1);

    // Frame 4: new position and flip in effect
    pix(20, 10, 6'h00, "db_old_gone");
    pix(81, 10, 6'h00, "flip_lx40");
    pix(82, 10, 6'h30, "flip_lx41a");
    pix(83, 10, 6'h30, "flip_lx41b");
    pix(84, 10, 6'h00, "flip_lx42");

    // Disable: flags retained, output black
    wr(6'h00, 32'h0);
    rd(6'h04, 32'h1, "vpend_retained");
    check("irq_masked", 32'(user_interrupt), 32'h0);
    check("uo_disabled", 32'(uo_out), 32'h0);
    wr(6'h04, 32'h1);
    rd(6'h04, 32'h0, "vpend_cleared");

    // Priority / collision setup: sprites 0 and 2 overlap fully
    wr(6'h08, 32'h0000);
    for (int r = 0; r < 12; r++) wr(6'h0C, 32'hFFF);
    wr(6'h08, 32'h0002);
    for (int r = 0; r < 12; r++) wr(6'h0C, 32'hFFF);
    wr(6'h10, 32'h0008_0114);
    wr(6'h18, 32'h000B_0114);
    wr(6'h1C, 32'h0);
    rd(6'h18, 32'h000B_0114, "spr2_shadow");
    wr(6'h00, 32'h5);
    wait_at(0, V_TOTAL - 2, "c_f1_end");
    rd(6'h30, 32'h0, "coll_none_yet");

    pix(40, 2, 6'h3F, "prio_overlap");
    rd(6'h30, 32'h5, "coll_bits");
    rd(6'h04, 32'h2, "coll_pend");
    check("irq_coll", 32'(user_interrupt), 32'h1);

    wait_at(100, 2, "c_quiet");
    wr(6'h30, 32'h5);
    wr(6'h04, 32'h2);
    rd(6'h30, 32'h0, "coll_cleared");
    rd(6'h04, 32'h0, "cpend_cleared");
    check("irq_cleared", 32'(user_interrupt), 32'h0);

    wait_at(40, 3, "c_row3");
    wr(6'h04, 32'h2);
    rd(6'h04, 32'h2, "cpend_set_beats_clr");
    check("irq_again", 32'(user_interrupt), 32'h1);
    rd(6'h30, 32'h5, "coll_reset");
    wait_at(50, 3, "c_row3b");
    wr(6'h30, 32'h1);
    rd(6'h30, 32'h5, "coll_set_beats_clr");

    // Asynchronous reset mid-frame with sprites on screen
    pix(60, 3, 6'h3F, "pre_reset_pix");
    #2 rst_n = 1'b0;
    #1 check("async_uo", 32'(uo_out), 32'h0);
    check("async_irq", 32'(user_interrupt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(6'h00, 32'h0, "post_ctrl");
    rd(6'h04, 32'h0, "post_status");
    rd(6'h30, 32'h0, "post_coll");
    rd(6'h10, 32'h0, "post_spr0");
    rd(6'h18, 32'h0, "post_spr2");
    rd(6'h08, 32'h0, "post_ptr");
    rd(6'h0C, 32'h0, "post_bmp");
    check("post_uo", 32'(uo_out), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
